// File: rtl/loader_bridge.sv
// Bridges the HPS ioctl download stream to a core-side loader port.
// Bytes are buffered in a small FIFO and drained with an edge-acknowledged handshake.
module loader_bridge #(
    parameter int DEPTH = 8,
    parameter int AW    = 19,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic          ldr_oe,
    output logic [AW-1:0] ldr_adr,
    output logic [7:0]    ldr_wdat,
    output logic          ldr_wr,
    input  logic          ldr_ack,
    output logic          ldr_done,
    output logic          ovf,
    output logic          range_err,
    output logic [CW-1:0] count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACKWAIT = 2'd2
    } state_t;

    logic [AW+7:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic          ldr_wr_q, ldr_wr_d;
    logic [AW-1:0] ldr_adr_q, ldr_adr_d;
    logic [7:0]    ldr_wdat_q, ldr_wdat_d;
    logic          ldr_oe_q, ldr_oe_d;
    logic          ldr_done_q, ldr_done_d;
    logic          started_q, started_d;
    logic          pending_q, pending_d;
    logic          ovf_q, ovf_d;
    logic          range_err_q, range_err_d;
    logic          ack_prev_q;
    logic          dl_prev_q;

    logic strobe;
    logic in_range;
    logic full;
    logic push;
    logic pop;
    logic ack_rise;
    logic dl_rise;
    logic dl_fall;

    assign strobe   = ioctl_wr & ioctl_download & ~ldr_done_q;
    assign in_range = (ioctl_addr >> AW) == 25'd0;
    assign full     = count_q == CW'(DEPTH);
    assign push     = strobe & in_range & ~full;
    assign ack_rise = ldr_ack & ~ack_prev_q & ldr_wr_q;
    assign dl_rise  = ioctl_download & ~dl_prev_q;
    assign dl_fall  = ~ioctl_download & dl_prev_q;

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr_q] <= {ioctl_addr[AW-1:0], ioctl_dout};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Acknowledge is taken in REQ as well, so a fast core is never missed.
    always_comb begin
        state_d    = state_q;
        ldr_wr_d   = ldr_wr_q;
        ldr_adr_d  = ldr_adr_q;
        ldr_wdat_d = ldr_wdat_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d                 = REQ;
                    ldr_wr_d                = 1'b1;
                    {ldr_adr_d, ldr_wdat_d} = mem[rd_ptr_q];
                end
            end
            REQ, ACKWAIT: begin
                if (ack_rise) begin
                    pop      = 1'b1;
                    ldr_wr_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    state_d = ACKWAIT;
                end
            end
            default: begin
                state_d  = IDLE;
                ldr_wr_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        started_d   = started_q | dl_rise;
        pending_d   = pending_q | (dl_fall & started_q);
        ldr_done_d  = ldr_done_q |
                      (pending_q & (count_q == '0) & (state_q == IDLE));
        ldr_oe_d    = started_d & ~ldr_done_d;
        ovf_d       = ovf_q | (strobe & in_range & full);
        range_err_d = range_err_q | (strobe & ~in_range);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            ldr_wr_q    <= 1'b0;
            ldr_adr_q   <= '0;
            ldr_wdat_q  <= '0;
            ldr_oe_q    <= 1'b0;
            ldr_done_q  <= 1'b0;
            started_q   <= 1'b0;
            pending_q   <= 1'b0;
            ovf_q       <= 1'b0;
            range_err_q <= 1'b0;
            ack_prev_q  <= 1'b0;
            dl_prev_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            ldr_wr_q    <= ldr_wr_d;
            ldr_adr_q   <= ldr_adr_d;
            ldr_wdat_q  <= ldr_wdat_d;
            ldr_oe_q    <= ldr_oe_d;
            ldr_done_q  <= ldr_done_d;
            started_q   <= started_d;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            range_err_q <= range_err_d;
            ack_prev_q  <= ldr_ack;
            dl_prev_q   <= ioctl_download;
        end
    end

    assign ioctl_wait = (count_q >= CW'(DEPTH - 1)) & ~ldr_done_q;
    assign ldr_oe     = ldr_oe_q;
    assign ldr_adr    = ldr_adr_q;
    assign ldr_wdat   = ldr_wdat_q;
    assign ldr_wr     = ldr_wr_q;
    assign ldr_done   = ldr_done_q;
    assign ovf        = ovf_q;
    assign range_err  = range_err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_loader_bridge.sv
// Directed bench for loader_bridge: drain order, backpressure, overflow,
// range errors, held-ack behaviour, reset mid-transfer and done stickiness.
module tb_loader_bridge;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        ldr_oe;
    logic [18:0] ldr_adr;
    logic [7:0]  ldr_wdat;
    logic        ldr_wr;
    logic        ldr_ack;
    logic        ldr_done;
    logic        ovf;
    logic        range_err;
    logic [3:0]  count;

    int vectors = 0;
    int miscompares = 0;

    loader_bridge #(.DEPTH(8), .AW(19)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .ldr_oe         (ldr_oe),
        .ldr_adr        (ldr_adr),
        .ldr_wdat       (ldr_wdat),
        .ldr_wr         (ldr_wr),
        .ldr_ack        (ldr_ack),
        .ldr_done       (ldr_done),
        .ovf            (ovf),
        .range_err      (range_err),
        .count          (count)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_wr(input string tag);
        for (int n = 0; n < 20 && ldr_wr !== 1'b1; n++) tick();
        check(tag, ldr_wr, 1);
    endtask

    task automatic serve(input logic [18:0] a, input logic [7:0] d);
        wait_wr("wr_seen");
        check("wr_adr", ldr_adr, a);
        check("wr_dat", ldr_wdat, d);
        tick();
        tick();
        check("wr_stable_adr", ldr_adr, a);
        ldr_ack = 1'b1;
        tick();
        check("wr_cleared", ldr_wr, 0);
        ldr_ack = 1'b0;
        tick();
    endtask

    initial begin
        logic seen_wr;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ldr_ack        = 1'b0;
        tick();
        check("rst_count", count, 0);
        check("rst_wr", ldr_wr, 0);
        check("rst_oe", ldr_oe, 0);
        check("rst_done", ldr_done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_rerr", range_err, 0);
        check("rst_wait", ioctl_wait, 0);
        check("rst_adr", ldr_adr, 0);
        reset = 1'b0;
        tick();

        // basic three-byte download
        ioctl_download = 1'b1;
        tick();
        check("oe_on", ldr_oe, 1);
        strobe(25'h0, 8'hA5);
        strobe(25'h1, 8'h5A);
        strobe(25'h2, 8'h3C);
        serve(19'h0, 8'hA5);
        serve(19'h1, 8'h5A);
        serve(19'h2, 8'h3C);
        check("drain_count", count, 0);
        ioctl_download = 1'b0;
        tick();
        tick();
        check("done_set", ldr_done, 1);
        check("oe_off", ldr_oe, 0);

        // second download after done is ignored
        ioctl_download = 1'b1;
        tick();
        strobe(25'h10, 8'h77);
        check("post_done_wait", ioctl_wait, 0);
        strobe(25'h11, 8'h88);
        tick();
        check("post_done_count", count, 0);
        check("post_done_wr", ldr_wr, 0);
        check("post_done_done", ldr_done, 1);
        check("post_done_oe", ldr_oe, 0);
        ioctl_download = 1'b0;
        tick();

        // fill with ack low, range error, overflow
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_done", ldr_done, 0);
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) strobe(25'h10 + 25'(i), 8'(8'h40 + i));
        check("fill6_count", count, 6);
        check("fill6_wait", ioctl_wait, 0);
        strobe(25'h80000, 8'hFF);
        check("range_count", count, 6);
        check("range_err", range_err, 1);
        check("range_ovf", ovf, 0);
        strobe(25'h16, 8'h46);
        check("fill7_count", count, 7);
        check("fill7_wait", ioctl_wait, 1);
        strobe(25'h17, 8'h47);
        check("fill8_count", count, 8);
        check("fill8_ovf", ovf, 0);
        strobe(25'h18, 8'h48);
        check("ovf_count", count, 8);
        check("ovf_set", ovf, 1);
        check("head_wr", ldr_wr, 1);
        check("head_adr", ldr_adr, 19'h10);
        check("head_dat", ldr_wdat, 8'h40);
        tick();
        check("ovf_sticky", ovf, 1);

        // asynchronous reset mid-transfer
        reset = 1'b1;
        #1;
        check("arst_wr", ldr_wr, 0);
        check("arst_count", count, 0);
        check("arst_oe", ldr_oe, 0);
        check("arst_ovf", ovf, 0);
        check("arst_rerr", range_err, 0);
        ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        seen_wr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ldr_wr === 1'b1) seen_wr = 1'b1;
        end
        check("arst_no_wr", seen_wr, 0);

        // held ack and simultaneous push/pop
        ioctl_download = 1'b1;
        tick();
        strobe(25'h100, 8'h11);
        strobe(25'h101, 8'h22);
        check("ha_count", count, 2);
        check("ha_wr", ldr_wr, 1);
        check("ha_adr", ldr_adr, 19'h100);
        ldr_ack    = 1'b1;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h102;
        ioctl_dout = 8'h33;
        tick();
        ioctl_wr = 1'b0;
        check("pushpop_count", count, 2);
        check("pushpop_wr", ldr_wr, 0);
        tick();
        tick();
        tick();
        check("held_wr", ldr_wr, 1);
        check("held_adr", ldr_adr, 19'h101);
        check("held_dat", ldr_wdat, 8'h22);
        check("held_count", count, 2);
        ldr_ack = 1'b0;
        tick();
        ldr_ack = 1'b1;
        tick();
        check("rearm_count", count, 1);
        check("rearm_wr", ldr_wr, 0);
        ldr_ack = 1'b0;
        serve(19'h102, 8'h33);
        check("ha_empty", count, 0);
        ioctl_download = 1'b0;
        tick();
        tick();
        check("ha_done", ldr_done, 1);
        check("ha_oe", ldr_oe, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
